// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: machine word and the RAM status reported to the
// coherence controller.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

endpackage

// File: rtl/ram_array.sv
// Word-addressed backing store: one synchronous write port and one
// combinational read port. Contents are never reset.
module ram_array
   import cpu_types_pkg::*;
#(
   parameter int DEPTH = 1024,
   parameter int IW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [IW-1:0] waddr,
   input  word_t         wdata,
   input  logic [IW-1:0] raddr,
   output word_t         rdata
);

   word_t mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/ram_ctrl.sv
// RAM controller: holds each request for LAT BUSY cycles before a single
// ACCESS cycle; the debug port preloads the array ahead of requests.
module ram_ctrl
   import cpu_types_pkg::*;
#(
   parameter int LAT   = 2,
   parameter int DEPTH = 1024
) (
   input  logic      CLK,
   input  logic      nRST,
   input  logic      ramREN,
   input  logic      ramWEN,
   input  word_t     ramaddr,
   input  word_t     ramstore,
   output word_t     ramload,
   output ramstate_t ramstate,
   input  logic      dbgWEN,
   input  word_t     dbgaddr,
   input  word_t     dbgstore
);

   localparam int IW = $clog2(DEPTH);
   localparam int CW = (LAT > 0) ? $clog2(LAT + 1) : 1;
   localparam logic [CW-1:0] LAT_C = CW'(LAT);

   logic [33:0]   key;
   logic [33:0]   prev_key;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_eff;
   logic          req_valid;
   logic          req_both;
   logic          dbg_ok;
   logic          arr_we;
   logic [IW-1:0] arr_waddr;
   word_t         arr_wdata;
   word_t         arr_rdata;

   // Word aligned, and nothing set above the index field.
   function automatic logic addr_illegal(input word_t a);
      return (a[1:0] != 2'b00) || ((a >> (IW + 2)) != '0);
   endfunction

   assign key       = {ramREN, ramWEN, ramaddr};
   assign req_valid = ramREN ^ ramWEN;
   assign req_both  = ramREN & ramWEN;

   // A key differing from last cycle's is a fresh request starting at zero.
   always_comb begin
      cnt_eff  = (key != prev_key) ? '0 : cnt;
      ramstate = FREE;
      if (!nRST) begin
         ramstate = FREE;
      end else if (req_both) begin
         ramstate = ERROR;
      end else if (req_valid && addr_illegal(ramaddr)) begin
         ramstate = ERROR;
      end else if (req_valid && dbgWEN) begin
         ramstate = BUSY;
      end else if (req_valid && (cnt_eff == LAT_C)) begin
         ramstate = ACCESS;
      end else if (req_valid) begin
         ramstate = BUSY;
      end
   end

   // Debug preload stalls a pending request: counter and key both freeze.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         cnt      <= '0;
         prev_key <= '0;
      end else if (!(dbgWEN && (ramstate == BUSY))) begin
         prev_key <= key;
         if (ramstate == BUSY) begin
            cnt <= cnt_eff + CW'(1);
         end else begin
            cnt <= '0;
         end
      end
   end

   assign dbg_ok    = nRST && dbgWEN && !addr_illegal(dbgaddr);
   assign arr_we    = dbg_ok || ((ramstate == ACCESS) && ramWEN);
   assign arr_waddr = dbg_ok ? dbgaddr[IW+1:2] : ramaddr[IW+1:2];
   assign arr_wdata = dbg_ok ? dbgstore : ramstore;

   ram_array #(
      .DEPTH (DEPTH),
      .IW    (IW)
   ) u_array (
      .clk   (CLK),
      .we    (arr_we),
      .waddr (arr_waddr),
      .wdata (arr_wdata),
      .raddr (ramaddr[IW+1:2]),
      .rdata (arr_rdata)
   );

   assign ramload = ((ramstate == ACCESS) && ramREN) ? arr_rdata : '0;

endmodule

// File: tb/tb_ram_ctrl.sv
// Bench for ram_ctrl: a LAT=2 and a LAT=0 instance share all inputs; read
// data is checked against a scoreboard of expected load values.
module tb_ram_ctrl;
   import cpu_types_pkg::*;

   logic      CLK;
   logic      nRST;
   logic      ramREN;
   logic      ramWEN;
   word_t     ramaddr;
   word_t     ramstore;
   logic      dbgWEN;
   word_t     dbgaddr;
   word_t     dbgstore;
   word_t     load;
   word_t     load0;
   ramstate_t st;
   ramstate_t st0;

   int checks = 0;
   int errors = 0;
   int wr_cnt = 0;
   int wr_snap;
   logic [31:0] exp_q[$];
   logic [31:0] exp0_q[$];

   ram_ctrl #(.LAT(2), .DEPTH(1024)) dut (
      .CLK(CLK), .nRST(nRST), .ramREN(ramREN), .ramWEN(ramWEN),
      .ramaddr(ramaddr), .ramstore(ramstore), .ramload(load), .ramstate(st),
      .dbgWEN(dbgWEN), .dbgaddr(dbgaddr), .dbgstore(dbgstore)
   );

   ram_ctrl #(.LAT(0), .DEPTH(1024)) dut0 (
      .CLK(CLK), .nRST(nRST), .ramREN(ramREN), .ramWEN(ramWEN),
      .ramaddr(ramaddr), .ramstore(ramstore), .ramload(load0), .ramstate(st0),
      .dbgWEN(dbgWEN), .dbgaddr(dbgaddr), .dbgstore(dbgstore)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   // Request-port writes on the LAT=2 instance, debug preloads excluded.
   always @(posedge CLK) begin
      if (dut.arr_we && !dbgWEN) wr_cnt++;
   end

   // Scoreboard: every read ACCESS consumes one expected load value.
   always @(negedge CLK) begin
      if (nRST && ramREN && (st == ACCESS)) begin
         if (exp_q.size() == 0) check("sb_unexpected", load, 32'hFFFF_FFFF);
         else check("sb_load", load, exp_q.pop_front());
      end
      if (nRST && ramREN && (st0 == ACCESS)) begin
         if (exp0_q.size() == 0) check("sb0_unexpected", load0, 32'hFFFF_FFFF);
         else check("sb0_load", load0, exp0_q.pop_front());
      end
   end

   // One clock with the inputs already driven; ld is the word a read ACCESS returns.
   task automatic cycle(input string tag, input ramstate_t e, input ramstate_t e0,
                        input logic [31:0] ld);
      if (ramREN && (e == ACCESS)) exp_q.push_back(ld);
      if (ramREN && (e0 == ACCESS)) exp0_q.push_back(ld);
      @(negedge CLK);
      check({tag, "/st"}, 32'(st), 32'(e));
      check({tag, "/st0"}, 32'(st0), 32'(e0));
      if (!(ramREN && (e == ACCESS))) check({tag, "/ld"}, load, 32'h0);
      if (!(ramREN && (e0 == ACCESS))) check({tag, "/ld0"}, load0, 32'h0);
      @(posedge CLK);
      #1;
   endtask

   task automatic idle(input string tag);
      ramREN = 1'b0;
      ramWEN = 1'b0;
      cycle(tag, FREE, FREE, 32'h0);
   endtask

   task automatic dbg_write(input word_t a, input word_t d);
      dbgWEN   = 1'b1;
      dbgaddr  = a;
      dbgstore = d;
      @(posedge CLK);
      #1;
      dbgWEN = 1'b0;
   endtask

   task automatic req(input logic r, input logic w, input word_t a, input word_t d);
      ramREN   = r;
      ramWEN   = w;
      ramaddr  = a;
      ramstore = d;
   endtask

   initial begin
      nRST = 1'b0;
      dbgWEN = 1'b0; dbgaddr = '0; dbgstore = '0;
      req(1'b1, 1'b0, 32'h40, 32'h0);
      @(posedge CLK);
      #1;
      cycle("reset_a", FREE, FREE, 32'h0);
      cycle("reset_b", FREE, FREE, 32'h0);
      nRST = 1'b1;
      req(1'b0, 1'b0, 32'h0, 32'h0);
      dbg_write(32'h00, 32'h0000_00A0);
      dbg_write(32'h04, 32'h0000_00A4);
      dbg_write(32'h08, 32'h0000_00A8);
      dbg_write(32'h40, 32'hDEAD_BEEF);
      dbg_write(32'h44, 32'hCAFE_F00D);
      dbg_write(32'h48, 32'h1111_1111);
      idle("idle0");

      // Held read: BUSY, BUSY, ACCESS, then a fresh transaction.
      req(1'b1, 1'b0, 32'h40, 32'h0);
      cycle("rd40_0", BUSY, ACCESS, 32'hDEAD_BEEF);
      cycle("rd40_1", BUSY, ACCESS, 32'hDEAD_BEEF);
      cycle("rd40_2", ACCESS, ACCESS, 32'hDEAD_BEEF);
      cycle("rd40_3", BUSY, ACCESS, 32'hDEAD_BEEF);
      idle("idle1");

      // Write 0x80 then read it back; exactly one array write.
      wr_snap = wr_cnt;
      req(1'b0, 1'b1, 32'h80, 32'h1234_5678);
      cycle("wr80_0", BUSY, ACCESS, 32'h0);
      cycle("wr80_1", BUSY, ACCESS, 32'h0);
      cycle("wr80_2", ACCESS, ACCESS, 32'h0);
      req(1'b1, 1'b0, 32'h80, 32'h0);
      cycle("rd80_0", BUSY, ACCESS, 32'h1234_5678);
      cycle("rd80_1", BUSY, ACCESS, 32'h1234_5678);
      cycle("rd80_2", ACCESS, ACCESS, 32'h1234_5678);
      check("wr80_count", 32'(wr_cnt - wr_snap), 32'd1);
      idle("idle2");

      // Read-after-write on consecutive cycles (LAT=0 instance).
      req(1'b0, 1'b1, 32'h84, 32'h55AA_55AA);
      cycle("raw_w", BUSY, ACCESS, 32'h0);
      req(1'b1, 1'b0, 32'h84, 32'h0);
      cycle("raw_r", BUSY, ACCESS, 32'h55AA_55AA);
      idle("idle3");

      // Address change mid-BUSY restarts the latency.
      req(1'b1, 1'b0, 32'h40, 32'h0);
      cycle("chg_40", BUSY, ACCESS, 32'hDEAD_BEEF);
      req(1'b1, 1'b0, 32'h44, 32'h0);
      cycle("chg_44a", BUSY, ACCESS, 32'hCAFE_F00D);
      cycle("chg_44b", BUSY, ACCESS, 32'hCAFE_F00D);
      cycle("chg_44c", ACCESS, ACCESS, 32'hCAFE_F00D);
      idle("idle4");

      // Error cases leave the array untouched.
      req(1'b1, 1'b1, 32'h40, 32'h0BAD_0BAD);
      for (int i = 0; i < 3; i++) cycle("err_both", ERROR, ERROR, 32'h0);
      req(1'b1, 1'b0, 32'h42, 32'h0);
      cycle("err_align", ERROR, ERROR, 32'h0);
      req(1'b0, 1'b1, 32'h1040, 32'h0BAD_0BAD);
      cycle("err_high", ERROR, ERROR, 32'h0);
      idle("idle5");
      req(1'b1, 1'b0, 32'h40, 32'h0);
      cycle("post_err0", BUSY, ACCESS, 32'hDEAD_BEEF);
      cycle("post_err1", BUSY, ACCESS, 32'hDEAD_BEEF);
      cycle("post_err2", ACCESS, ACCESS, 32'hDEAD_BEEF);
      idle("idle6");

      // Back-to-back reads: LAT=0 accesses every cycle.
      req(1'b1, 1'b0, 32'h0, 32'h0);
      cycle("b2b_0", BUSY, ACCESS, 32'h0000_00A0);
      req(1'b1, 1'b0, 32'h4, 32'h0);
      cycle("b2b_4", BUSY, ACCESS, 32'h0000_00A4);
      req(1'b1, 1'b0, 32'h8, 32'h0);
      cycle("b2b_8", BUSY, ACCESS, 32'h0000_00A8);
      idle("idle7");

      // Debug preload stalls a held read without clearing its progress.
      req(1'b1, 1'b0, 32'h40, 32'h0);
      cycle("dbg_a", BUSY, ACCESS, 32'hDEAD_BEEF);
      dbgWEN = 1'b1; dbgaddr = 32'h200; dbgstore = 32'h7777_7777;
      cycle("dbg_b", BUSY, BUSY, 32'h0);
      dbgaddr = 32'h202; dbgstore = 32'h9999_9999;
      cycle("dbg_c", BUSY, BUSY, 32'h0);
      dbgWEN = 1'b0;
      cycle("dbg_d", BUSY, ACCESS, 32'hDEAD_BEEF);
      cycle("dbg_e", ACCESS, ACCESS, 32'hDEAD_BEEF);
      req(1'b1, 1'b0, 32'h200, 32'h0);
      cycle("dbg_rd", BUSY, ACCESS, 32'h7777_7777);
      idle("idle8");

      // Reset mid-BUSY on a write abandons it; debug writes ignored in reset.
      wr_snap = wr_cnt;
      req(1'b0, 1'b1, 32'h100, 32'hA5A5_A5A5);
      cycle("rst_w0", BUSY, ACCESS, 32'h0);
      nRST = 1'b0;
      dbgWEN = 1'b1; dbgaddr = 32'h48; dbgstore = 32'h0BAD_0BAD;
      cycle("rst_w1", FREE, FREE, 32'h0);
      nRST = 1'b1;
      dbgWEN = 1'b0;
      check("rst_nowrite", 32'(wr_cnt - wr_snap), 32'd0);
      cycle("rst_w2", BUSY, ACCESS, 32'h0);
      cycle("rst_w3", BUSY, ACCESS, 32'h0);
      cycle("rst_w4", ACCESS, ACCESS, 32'h0);
      check("rst_wcount", 32'(wr_cnt - wr_snap), 32'd1);
      req(1'b1, 1'b0, 32'h100, 32'h0);
      cycle("rst_r100", BUSY, ACCESS, 32'hA5A5_A5A5);
      req(1'b1, 1'b0, 32'h48, 32'h0);
      cycle("rst_r48", BUSY, ACCESS, 32'h1111_1111);
      idle("idle9");

      check("sb_drain", 32'(exp_q.size() + exp0_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
